// File: rtl/cache_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_line_fill_ctrl
//
// Purpose:
//   Services one cache miss at a time for the 4-way x 512-segment data array.
//   It reads the victim line and its dirty bit. If the line is dirty it writes
//   it back to memory. It then fetches the new line and full-writes it into
//   the array at the victim position.
//
// Ports:
//   main_clk, main_rst_n     clock, asynchronous active-low reset
//   miss_*                   miss request from tag/hit logic (valid/ready)
//   fill_done, busy          completion pulse / stall indication
//   arr_*                    data-array control, write data, read data, dirty
//   mem_wr_*                 writeback request to memory (valid/ready)
//   mem_rd_*                 fetch request to memory (valid/ready)
//   mem_rsp_*                fetch response, one beat per accepted fetch
//   dbg_state                current FSM state, for checkers and debug
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised, the address and data stay stable until
// that edge. Valid never depends on ready.
// ---------------------------------------------------------------------------
module cache_line_fill_ctrl #(
   parameter int LINE_ADDR_W = 26,
   parameter int RD_LAT      = 2
) (
   input  logic                   main_clk,
   input  logic                   main_rst_n,
   input  logic                   miss_valid,
   output logic                   miss_ready,
   input  logic [8:0]             miss_segment,
   input  logic [1:0]             miss_way,
   input  logic [LINE_ADDR_W-1:0] miss_line_addr,
   input  logic [LINE_ADDR_W-1:0] victim_line_addr,
   output logic                   fill_done,
   output logic                   busy,
   output logic [8:0]             arr_segment,
   output logic [1:0]             arr_way_read,
   output logic [1:0]             arr_way_write,
   output logic                   arr_full_write,
   output logic [127:0]           arr_wdata,
   input  logic [127:0]           arr_rdata,
   input  logic                   arr_dirty,
   output logic                   mem_wr_valid,
   input  logic                   mem_wr_ready,
   output logic [LINE_ADDR_W-1:0] mem_wr_addr,
   output logic [127:0]           mem_wr_data,
   output logic                   mem_rd_valid,
   input  logic                   mem_rd_ready,
   output logic [LINE_ADDR_W-1:0] mem_rd_addr,
   input  logic                   mem_rsp_valid,
   input  logic [127:0]           mem_rsp_data,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VREAD  = 3'd1,
      S_WB     = 3'd2,
      S_FETCH  = 3'd3,
      S_FWAIT  = 3'd4,
      S_FWRITE = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [1:0] RD_LAT_C = RD_LAT[1:0];

   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [8:0]             seg_q, seg_d;
   logic [1:0]             way_q, way_d;
   logic [LINE_ADDR_W-1:0] miss_addr_q, miss_addr_d;
   logic [LINE_ADDR_W-1:0] victim_addr_q, victim_addr_d;
   logic [127:0]           vdata_q, vdata_d;
   logic [127:0]           wdata_q, wdata_d;

   // The array address is driven from the first VREAD cycle, so read data is
   // valid RD_LAT cycles later. That is the cycle in which cnt_q reaches RD_LAT.
   logic rd_sample;
   assign rd_sample = (state_q == S_VREAD) && (cnt_q == RD_LAT_C);

   // ---------------- state register ----------------
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (miss_valid)    state_d = S_VREAD;
         S_VREAD:  if (rd_sample)     state_d = arr_dirty ? S_WB : S_FETCH;
         // The fetch is issued only after the writeback has been accepted. A
         // reused address therefore cannot read stale memory.
         S_WB:     if (mem_wr_ready)  state_d = S_FETCH;
         S_FETCH:  if (mem_rd_ready)  state_d = S_FWAIT;
         S_FWAIT:  if (mem_rsp_valid) state_d = S_FWRITE;
         S_FWRITE:                    state_d = S_DONE;
         S_DONE:                      state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         cnt_q         <= '0;
         seg_q         <= '0;
         way_q         <= '0;
         miss_addr_q   <= '0;
         victim_addr_q <= '0;
         vdata_q       <= '0;
         wdata_q       <= '0;
      end else begin
         cnt_q         <= cnt_d;
         seg_q         <= seg_d;
         way_q         <= way_d;
         miss_addr_q   <= miss_addr_d;
         victim_addr_q <= victim_addr_d;
         vdata_q       <= vdata_d;
         wdata_q       <= wdata_d;
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      seg_d         = seg_q;
      way_d         = way_q;
      miss_addr_d   = miss_addr_q;
      victim_addr_d = victim_addr_q;
      vdata_d       = vdata_q;
      wdata_d       = wdata_q;
      case (state_q)
         S_IDLE: begin
            // Request fields are captured only on acceptance. Requests made
            // while busy have no effect.
            if (miss_valid) begin
               seg_d         = miss_segment;
               way_d         = miss_way;
               miss_addr_d   = miss_line_addr;
               victim_addr_d = victim_line_addr;
               cnt_d         = '0;
            end
         end
         S_VREAD: begin
            cnt_d = cnt_q + 2'd1;
            if (rd_sample) begin
               vdata_d = arr_rdata;
            end
         end
         S_FWAIT: begin
            if (mem_rsp_valid) begin
               wdata_d = mem_rsp_data;
            end
         end
         default: ;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      miss_ready     = (state_q == S_IDLE);
      busy           = (state_q != S_IDLE) && (state_q != S_DONE);
      fill_done      = (state_q == S_DONE);
      arr_segment    = busy ? seg_q : '0;
      arr_way_read   = (state_q == S_VREAD) ? way_q : '0;
      arr_way_write  = (state_q == S_FWRITE) ? way_q : '0;
      arr_full_write = (state_q == S_FWRITE);
      arr_wdata      = wdata_q;
      mem_wr_valid   = (state_q == S_WB);
      mem_wr_addr    = (state_q == S_WB) ? victim_addr_q : '0;
      mem_wr_data    = (state_q == S_WB) ? vdata_q : '0;
      mem_rd_valid   = (state_q == S_FETCH);
      mem_rd_addr    = (state_q == S_FETCH) ? miss_addr_q : '0;
      dbg_state      = state_q;
   end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_line_fill_ctrl
//
// Purpose:
//   Directed bench for cache_line_fill_ctrl. A table of miss scenarios
//   (request fields, array contents, memory stall profile, hand-computed
//   latency) is applied in a loop. Hand-written sequences cover back-to-back
//   misses and reset during FWAIT. A small array model returns read data
//   RD_LAT cycles after the address was presented, so an early or late
//   sample picks up junk data.
// ---------------------------------------------------------------------------
module tb_cache_line_fill_ctrl;

  localparam int LINE_ADDR_W = 26;
  localparam int RD_LAT      = 2;
  localparam int W           = 139;  // {way, segment, line data}

  // ---------------- clock / reset ----------------
  logic                   main_clk;
  logic                   main_rst_n;
  logic                   miss_valid;
  logic                   miss_ready;
  logic [8:0]             miss_segment;
  logic [1:0]             miss_way;
  logic [LINE_ADDR_W-1:0] miss_line_addr;
  logic [LINE_ADDR_W-1:0] victim_line_addr;
  logic                   fill_done;
  logic                   busy;
  logic [8:0]             arr_segment;
  logic [1:0]             arr_way_read;
  logic [1:0]             arr_way_write;
  logic                   arr_full_write;
  logic [127:0]           arr_wdata;
  logic [127:0]           arr_rdata;
  logic                   arr_dirty;
  logic                   mem_wr_valid;
  logic                   mem_wr_ready;
  logic [LINE_ADDR_W-1:0] mem_wr_addr;
  logic [127:0]           mem_wr_data;
  logic                   mem_rd_valid;
  logic                   mem_rd_ready;
  logic [LINE_ADDR_W-1:0] mem_rd_addr;
  logic                   mem_rsp_valid;
  logic [127:0]           mem_rsp_data;
  logic [2:0]             dbg_state;

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  cache_line_fill_ctrl #(
    .LINE_ADDR_W(LINE_ADDR_W),
    .RD_LAT     (RD_LAT)
  ) dut (
    .main_clk        (main_clk),
    .main_rst_n      (main_rst_n),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_segment    (miss_segment),
    .miss_way        (miss_way),
    .miss_line_addr  (miss_line_addr),
    .victim_line_addr(victim_line_addr),
    .fill_done       (fill_done),
    .busy            (busy),
    .arr_segment     (arr_segment),
    .arr_way_read    (arr_way_read),
    .arr_way_write   (arr_way_write),
    .arr_full_write  (arr_full_write),
    .arr_wdata       (arr_wdata),
    .arr_rdata       (arr_rdata),
    .arr_dirty       (arr_dirty),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_ready    (mem_wr_ready),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_ready    (mem_rd_ready),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .dbg_state       (dbg_state)
  );

  // ---------------- scenario table ----------------
  typedef struct {
    logic [8:0]             seg;
    logic [1:0]             way;
    logic [LINE_ADDR_W-1:0] miss_addr;
    logic [LINE_ADDR_W-1:0] victim_addr;
    logic                   dirty;
    logic [127:0]           rdata;
    logic [127:0]           rsp_data;
    int                     wr_stall;   // cycles mem_wr_ready held low
    int                     rd_stall;   // cycles mem_rd_ready held low
    int                     rsp_delay;  // extra FWAIT cycles before response
    int                     exp_lat;    // accept edge -> fill_done cycle
    int                     exp_wb;     // expected writeback handshakes
  } vec_t;

  vec_t vecs[5];
  vec_t cur;  // contents currently held by the array model

  // ---------------- array model ----------------
  // The address is sampled each negedge. The data matches only when the
  // address seen RD_LAT cycles earlier is the victim location.
  logic [8:0] pipe_seg[RD_LAT+1];
  logic [1:0] pipe_way[RD_LAT+1];

  always @(negedge main_clk) begin
    for (int i = RD_LAT; i > 0; i--) begin
      pipe_seg[i] = pipe_seg[i-1];
      pipe_way[i] = pipe_way[i-1];
    end
    pipe_seg[0] = arr_segment;
    pipe_way[0] = arr_way_read;
    if (pipe_seg[RD_LAT] == cur.seg && pipe_way[RD_LAT] == cur.way) begin
      arr_dirty = cur.dirty;
      arr_rdata = cur.rdata;
    end else begin
      arr_dirty = ~cur.dirty;
      arr_rdata = ~cur.rdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_vec(input vec_t v, input bit hold);
    int  lat = 0, wr_cyc = 0, rd_cyc = 0, wr_hs = 0, rd_hs = 0, rd_hs_cyc = 0, fw_cnt = 0;
    bit  bad_wr = 0, bad_rd = 0, bad_order = 0, bad_busy = 0, bad_ready = 0, rsp_sent = 0;
    @(negedge main_clk);
    cur              = v;
    miss_valid       = 1'b1;
    miss_segment     = v.seg;
    miss_way         = v.way;
    miss_line_addr   = v.miss_addr;
    victim_line_addr = v.victim_addr;
    chk("ready_in_idle", miss_ready, 1);
    exp_q.push_back({v.way, v.seg, v.rsp_data});
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge main_clk);
      if (hold) begin
        // The request is held while busy with changing fields. None of them
        // may leak into the fill in progress.
        miss_segment     = 9'($urandom);
        miss_way         = 2'($urandom);
        miss_line_addr   = 26'($urandom);
        victim_line_addr = 26'($urandom);
      end else begin
        miss_valid = 1'b0;
      end
      if (miss_ready) bad_ready = 1;
      if (!fill_done && !busy) bad_busy = 1;
      mem_wr_ready  = 1'b0;
      mem_rd_ready  = 1'b0;
      mem_rsp_valid = 1'b0;
      if (mem_wr_valid) begin
        wr_cyc++;
        if (mem_wr_addr !== v.victim_addr || mem_wr_data !== v.rdata) bad_wr = 1;
        if (wr_cyc > v.wr_stall) begin
          mem_wr_ready = 1'b1;
          wr_hs++;
        end
      end
      if (mem_rd_valid) begin
        if (wr_hs != v.exp_wb || mem_wr_valid) bad_order = 1;
        rd_cyc++;
        if (mem_rd_addr !== v.miss_addr) bad_rd = 1;
        if (rd_cyc > v.rd_stall) begin
          mem_rd_ready = 1'b1;
          rd_hs++;
          rd_hs_cyc = n;
        end
      end
      if (rd_hs > 0 && !rsp_sent && n == rd_hs_cyc + 1 + v.rsp_delay) begin
        mem_rsp_valid = 1'b1;
        rsp_sent      = 1;
      end
      mem_rsp_data = mem_rsp_valid ? v.rsp_data : ~v.rsp_data;
      if (arr_full_write) begin
        fw_cnt++;
        if (exp_q.size() == 0) chk("arr_write_unexpected", 1, 0);
        else chk("arr_write_way_seg_data", {arr_way_write, arr_segment, arr_wdata}, exp_q.pop_front());
      end
      if (fill_done) lat = n;
    end
    chk("fill_latency", lat, v.exp_lat);
    chk("wb_handshakes", wr_hs, v.exp_wb);
    chk("fetch_handshakes", rd_hs, 1);
    chk("full_write_count", fw_cnt, 1);
    chk("wb_addr_data_stable", bad_wr, 0);
    chk("fetch_addr_stable", bad_rd, 0);
    chk("wb_before_fetch", bad_order, 0);
    chk("busy_window", bad_busy, 0);
    chk("ready_low_while_busy", bad_ready, 0);
  endtask

  // Reset asserted in FWAIT: outputs drop at once, and a late response
  // must not cause a fill.
  task automatic reset_in_fwait(input vec_t v);
    bit got = 0, bad = 0;
    @(negedge main_clk);
    cur              = v;
    miss_valid       = 1'b1;
    miss_segment     = v.seg;
    miss_way         = v.way;
    miss_line_addr   = v.miss_addr;
    victim_line_addr = v.victim_addr;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge main_clk);
      miss_valid   = 1'b0;
      mem_rd_ready = 1'b0;
      if (mem_rd_valid) begin
        mem_rd_ready = 1'b1;
        got          = 1;
      end
    end
    chk("rst_seq_fetch_seen", got, 1);
    @(negedge main_clk);
    mem_rd_ready = 1'b0;
    chk("rst_seq_busy_in_fwait", busy, 1);
    #2 main_rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl_zero",
        {busy, fill_done, arr_full_write, mem_rd_valid, mem_wr_valid, arr_segment,
         arr_way_read, arr_way_write, mem_rd_addr, mem_wr_addr, dbg_state}, 0);
    chk("rst_async_data_zero", arr_wdata | mem_wr_data, 0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    @(negedge main_clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    for (int k = 0; k < 6; k++) begin
      @(negedge main_clk);
      mem_rsp_valid = 1'b0;
      if (arr_full_write || fill_done || busy || !miss_ready) bad = 1;
    end
    chk("no_fill_after_reset", bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    main_rst_n       = 1'b0;
    miss_valid       = 1'b0;
    miss_segment     = '0;
    miss_way         = '0;
    miss_line_addr   = '0;
    victim_line_addr = '0;
    mem_wr_ready     = 1'b0;
    mem_rd_ready     = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_data     = '0;

    //          seg     way   miss_addr     victim_addr  dirty rdata                                        rsp_data                                     wr rd rsp lat wb
    vecs[0] = '{9'h1A3, 2'd2, 26'h2ABCDEF, 26'h1111111, 1'b0, 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555, 128'hCAFE_F00D_0123_4567_89AB_CDEF_1357_9BDF, 0, 0, 0, 7,  0};
    vecs[1] = '{9'h055, 2'd1, 26'h3000001, 26'h0123456, 1'b1, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF,       128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 0, 0, 0, 8,  1};
    vecs[2] = '{9'h1FF, 2'd3, 26'h3FFFFFF, 26'h2468ACE, 1'b1, 128'h0F0F_0F0F_F0F0_F0F0_1234_0000_FFFF_8001, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 5, 3, 0, 16, 1};
    vecs[3] = '{9'h000, 2'd0, 26'h0000010, 26'h0000020, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 0, 2, 4, 13, 0};
    vecs[4] = '{9'h100, 2'd2, 26'h1555555, 26'h2AAAAAA, 1'b1, 128'hBEEF_0000_BEEF_0000_BEEF_0000_BEEF_0000, 128'h0BAD_C0DE_0BAD_C0DE_0BAD_C0DE_0BAD_C0DE, 1, 0, 2, 11, 1};
    cur = vecs[0];

    // Reset state, checked during reset and after release.
    #1;
    chk("in_reset_ctrl_zero",
        {busy, fill_done, arr_full_write, mem_rd_valid, mem_wr_valid, arr_segment,
         arr_way_read, arr_way_write, mem_rd_addr, mem_wr_addr, dbg_state}, 0);
    repeat (3) @(negedge main_clk);
    main_rst_n = 1'b1;
    @(negedge main_clk);
    chk("post_reset_ready", miss_ready, 1);
    chk("post_reset_idle_outputs",
        {busy, fill_done, arr_full_write, mem_rd_valid, mem_wr_valid, arr_segment,
         arr_way_read, arr_way_write, mem_rd_addr, mem_wr_addr, dbg_state}, 0);
    chk("post_reset_data_zero", arr_wdata | mem_wr_data, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Back-to-back: the request stays high through the first fill. The second
    // miss must be accepted in the IDLE cycle after fill_done.
    run_vec(vecs[1], 1'b1);
    run_vec(vecs[0], 1'b0);

    reset_in_fwait(vecs[0]);
    run_vec(vecs[4], 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
